cpu_dout_dispatch: RTL and testbench
====================================

Name: cpu_dout_dispatch

Overview:
Write-side counterpart of the Z80 data-in selector. Captures Z80 DATA OUT on each CPU write cycle and routes it to the selected on-chip destination: LED latch, IOBYTE latch, USB UART transmit queue, or S100 output bus with a timed write strobe. Runs in the pll0_250MHz domain and samples the slower Z80 write strobe through a synchronizer. Asserts a wait request to the CPU while the USB transmit path cannot accept a byte.

Parameters:
SYNC_STAGES, 2, flops in the z80Write synchronizer (minimum 2)
S100_WR_CYCLES, 25, pll0_250MHz cycles the s100Wr pulse stays high (100 ns)
USB_FIFO_DEPTH, 4, USB TX queue entries (power of 2, minimum 2)

Ports:
pll0_250MHz  input  1  system clock, all logic rising-edge
n_reset  input  1  asynchronous, active-low reset
cpuDataOut  input  8  Z80 DATA OUT bus
z80Write  input  1  Z80 write strobe, active high, asynchronous to pll0_250MHz
outLED_cs  input  1  LED port write select
iobyteOut_cs  input  1  IOBYTE port write select
usbTxD_cs  input  1  USB TX data port write select
outPortcon_cs  input  1  S100 output-port write select
usbTxReady  input  1  USB UART accepts a byte this cycle
ledOut  output  8  LED latch
iobyteOut  output  8  IOBYTE latch
usbTxData  output  8  byte offered to USB UART
usbTxValid  output  1  usbTxData valid
s100DataOut  output  8  S100 output data
s100Wr  output  1  S100 write strobe, active high
z80Wait  output  1  wait request to CPU, active high

Behaviour:
- Reset (async assert, sync release): ledOut=8'h00, iobyteOut=8'hFF, usbTxValid=0, usbTxData=8'h00, s100DataOut=8'h00, s100Wr=0, z80Wait=0, FIFO empty, S100 FSM in IDLE.
- z80Write passes through SYNC_STAGES flops. A write event (wev) is a single-cycle pulse on the synchronized rising edge. cpuDataOut and all *_cs are sampled on the wev cycle; they are stable for the whole Z80 write cycle.
- Priority on wev when several selects are high: outLED_cs > iobyteOut_cs > usbTxD_cs > outPortcon_cs. Only one destination is written. No select high: event ignored.
- LED/IOBYTE: the latch updates the cycle after wev and holds until the next write or reset.
- USB TX: on wev with usbTxD_cs and FIFO not full, push cpuDataOut. usbTxValid is high whenever the FIFO is non-empty and usbTxData is the head entry. A pop occurs when usbTxValid && usbTxReady. A simultaneous push and pop on a full FIFO is accepted and the count is unchanged. Push on full: the byte is held in a pending register, z80Wait=1 the next cycle, and the byte is pushed on the first cycle a slot frees; z80Wait then drops the following cycle. Bytes are never dropped.
- z80Wait also asserts combinationally-registered while usbTxD_cs && z80Write_sync && FIFO full && no pending byte, so the CPU stalls before a second write.
- S100 FSM:
  - IDLE: on wev with outPortcon_cs, load s100DataOut and go to STROBE.
  - STROBE: s100Wr=1 for S100_WR_CYCLES cycles via a counter, then go to HOLD.
  - HOLD: s100Wr=0 and stay until the synchronized z80Write is low, then go to IDLE.
  - Any new wev arriving outside IDLE is ignored. s100DataOut holds its value after the strobe.
- Reset mid-operation: every state clears immediately and any pending or queued USB bytes are lost.

Optional Feature:
USB_TX_FIFO_EN
- Defined: USB path uses the USB_FIFO_DEPTH queue as described.
- Undefined: single holding register (depth 1). Full means the register is valid. Wait and pending rules are unchanged.

Decomposition:
- Package cpu_dout_pkg: S100 FSM state enum (IDLE, STROBE, HOLD), reset constants LED_RST=8'h00, IOBYTE_RST=8'hFF, select-priority encoding.
- Sub-module: usb_tx_fifo (synchronous FIFO with push/pop/full/empty/count, depth parameter, n_reset). The top contains the synchronizer, edge detect, latches, pending register and S100 FSM.

Test Plan:
- Write 8'hA5 with outLED_cs -> ledOut=8'hA5 within SYNC_STAGES+2 cycles of the z80Write rise. iobyteOut stays 8'hFF; no s100Wr.
- Write 8'h3C with outLED_cs and iobyteOut_cs both high -> ledOut=8'h3C, iobyteOut unchanged.
- usbTxReady=0, five usbTxD_cs writes 8'h01..8'h05 -> FIFO full after 4. Fifth write raises z80Wait. Release usbTxReady -> bytes emerge 01,02,03,04,05 in order and z80Wait drops once 05 is queued.
- outPortcon_cs write 8'h7E -> s100DataOut=8'h7E and s100Wr high for exactly 25 cycles. With z80Write held high, a second wev does not retrigger; a new write after z80Write falls does retrigger.
- Assert n_reset=0 mid-STROBE with 2 bytes queued -> s100Wr=0, usbTxValid=0, ledOut=8'h00, iobyteOut=8'hFF immediately.
- Build without USB_TX_FIFO_EN: two back-to-back USB writes with usbTxReady=0 -> z80Wait asserted on the second write; first byte presented until accepted.

Source files
------------

// File: rtl/cpu_dout_pkg.sv
// Shared types and constants for the Z80 write-side dispatcher: S100 strobe
// states, latch reset values and the write-select priority decode.
package cpu_dout_pkg;

   typedef enum logic [1:0] {IDLE, STROBE, HOLD} s100State_t;

   typedef enum logic [2:0] {SEL_NONE, SEL_LED, SEL_IOBYTE, SEL_USB, SEL_S100} wrSel_t;

   localparam logic [7:0] LED_RST    = 8'h00;
   localparam logic [7:0] IOBYTE_RST = 8'hFF;

   // LED > IOBYTE > USB > S100; at most one destination per write.
   function automatic wrSel_t selDecode(input logic ledCs, input logic iobyteCs,
                                        input logic usbCs, input logic portCs);
      if (ledCs)         return SEL_LED;
      else if (iobyteCs) return SEL_IOBYTE;
      else if (usbCs)    return SEL_USB;
      else if (portCs)   return SEL_S100;
      else               return SEL_NONE;
   endfunction

endpackage

// File: rtl/usb_tx_fifo.sv
// Byte FIFO feeding the USB UART. DEPTH of 1 degenerates to a holding register.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module usb_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic       push,
   input  logic [7:0] pushData,
   input  logic       pop,
   output logic [7:0] headData,
   output logic       full,
   output logic       empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [7:0]    mem [2**AW];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [CW-1:0] count;
   logic          doPush, doPop;

   function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign doPop    = pop && !empty;
   assign doPush   = push && (!full || doPop);
   assign headData = mem[rdPtr];

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= nextPtr(wrPtr);
         if (doPop)  rdPtr <= nextPtr(rdPtr);
         if (doPush && !doPop)      count <= count + CW'(1);
         else if (doPop && !doPush) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/cpu_dout_dispatch.sv
// Routes Z80 DATA OUT writes to the LED/IOBYTE latches, the USB TX queue or the S100 bus.
// Define USB_TX_FIFO_EN for a USB_FIFO_DEPTH queue; otherwise a single holding register.
module cpu_dout_dispatch
   import cpu_dout_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int S100_WR_CYCLES = 25,
   parameter int USB_FIFO_DEPTH = 4
) (
   input  logic       pll0_250MHz,
   input  logic       n_reset,
   input  logic [7:0] cpuDataOut,
   input  logic       z80Write,
   input  logic       outLED_cs,
   input  logic       iobyteOut_cs,
   input  logic       usbTxD_cs,
   input  logic       outPortcon_cs,
   input  logic       usbTxReady,
   output logic [7:0] ledOut,
   output logic [7:0] iobyteOut,
   output logic [7:0] usbTxData,
   output logic       usbTxValid,
   output logic [7:0] s100DataOut,
   output logic       s100Wr,
   output logic       z80Wait
);

`ifdef USB_TX_FIFO_EN
   localparam int QDEPTH = USB_FIFO_DEPTH;
`else
   localparam int QDEPTH = 1;
`endif
   localparam int SCW = $clog2(S100_WR_CYCLES + 1);

   if (SYNC_STAGES < 2 || USB_FIFO_DEPTH < 2 ||
       (USB_FIFO_DEPTH & (USB_FIFO_DEPTH - 1)) != 0) begin : gBadParam
      $error("cpu_dout_dispatch: illegal SYNC_STAGES or USB_FIFO_DEPTH");
   end

   // Write strobe synchronizer and rising-edge detect
   logic [SYNC_STAGES-1:0] syncPipe;
   logic                   wrSync, wrSyncDly, wev;
   wrSel_t                 sel;

   assign wrSync = syncPipe[SYNC_STAGES-1];
   assign wev    = wrSync && !wrSyncDly;
   assign sel    = wev ? selDecode(outLED_cs, iobyteOut_cs, usbTxD_cs, outPortcon_cs) : SEL_NONE;

   always_ff @(posedge pll0_250MHz or negedge n_reset) begin
      if (!n_reset) begin
         syncPipe  <= '0;
         wrSyncDly <= 1'b0;
      end else begin
         syncPipe  <= {syncPipe[SYNC_STAGES-2:0], z80Write};
         wrSyncDly <= wrSync;
      end
   end

   always_ff @(posedge pll0_250MHz or negedge n_reset) begin
      if (!n_reset) begin
         ledOut    <= LED_RST;
         iobyteOut <= IOBYTE_RST;
      end else begin
         if (sel == SEL_LED)    ledOut    <= cpuDataOut;
         if (sel == SEL_IOBYTE) iobyteOut <= cpuDataOut;
      end
   end

   // USB path: a byte that finds the queue full parks in pendData and stalls the CPU.
   logic       fifoFull, fifoEmpty, fifoPop, fifoPush, canPush;
   logic [7:0] fifoHead, fifoPushData, pendData;
   logic       pendValid, pendSet, pendNext;

   assign usbTxValid = !fifoEmpty;
   assign usbTxData  = usbTxValid ? fifoHead : 8'h00;
   assign fifoPop    = usbTxValid && usbTxReady;
   assign canPush    = !fifoFull || fifoPop;

   always_comb begin
      fifoPush     = 1'b0;
      fifoPushData = cpuDataOut;
      pendSet      = 1'b0;
      if (pendValid) begin
         fifoPush     = canPush;
         fifoPushData = pendData;
      end else if (sel == SEL_USB) begin
         fifoPush = canPush;
         pendSet  = !canPush;
      end
   end

   assign pendNext = pendSet || (pendValid && !canPush);

   always_ff @(posedge pll0_250MHz or negedge n_reset) begin
      if (!n_reset) begin
         pendValid <= 1'b0;
         pendData  <= 8'h00;
         z80Wait   <= 1'b0;
      end else begin
         pendValid <= pendNext;
         if (pendSet) pendData <= cpuDataOut;
         // Also stall while a USB write is in flight against a full queue.
         z80Wait <= pendNext || (usbTxD_cs && wrSync && fifoFull && !pendValid);
      end
   end

   usb_tx_fifo #(.DEPTH(QDEPTH)) uTxFifo (
      .clk      (pll0_250MHz),
      .n_reset  (n_reset),
      .push     (fifoPush),
      .pushData (fifoPushData),
      .pop      (fifoPop),
      .headData (fifoHead),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

   // S100 output: fixed-width strobe, then wait for the Z80 write to end.
   s100State_t     s100State;
   logic [SCW-1:0] strobeCnt;

   always_ff @(posedge pll0_250MHz or negedge n_reset) begin
      if (!n_reset) begin
         s100State   <= IDLE;
         s100Wr      <= 1'b0;
         s100DataOut <= 8'h00;
         strobeCnt   <= '0;
      end else begin
         case (s100State)
            IDLE: if (sel == SEL_S100) begin
               s100DataOut <= cpuDataOut;
               s100Wr      <= 1'b1;
               strobeCnt   <= '0;
               s100State   <= STROBE;
            end
            STROBE: if (strobeCnt == SCW'(S100_WR_CYCLES - 1)) begin
               s100Wr    <= 1'b0;
               s100State <= HOLD;
            end else begin
               strobeCnt <= strobeCnt + SCW'(1);
            end
            HOLD: if (!wrSync) s100State <= IDLE;
            default: s100State <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_dout_dispatch.sv
// Scoreboard bench for cpu_dout_dispatch: stimulus pushes expected USB/S100
// traffic into queues, independent monitors pop and compare.
module tb_cpu_dout_dispatch;

   localparam int SYNC      = 2;
   localparam int WR_CYCLES = 25;
`ifdef USB_TX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic       clk = 1'b0;
   logic       n_reset = 1'b0;
   logic [7:0] cpuDataOut = 8'h00;
   logic       z80Write = 1'b0;
   logic       outLED_cs = 1'b0, iobyteOut_cs = 1'b0, usbTxD_cs = 1'b0, outPortcon_cs = 1'b0;
   logic       usbTxReady = 1'b0;
   logic [7:0] ledOut, iobyteOut, usbTxData, s100DataOut;
   logic       usbTxValid, s100Wr, z80Wait;

   int         passed = 0, total = 0;
   int         readyMode = 0;   // 0 low, 1 high, 2 random
   logic [7:0] ledExp = 8'h00, ioExp = 8'hFF;
   logic [7:0] usbQ [$];
   logic [7:0] s100Q [$];

   cpu_dout_dispatch dut (
      .pll0_250MHz   (clk),
      .n_reset       (n_reset),
      .cpuDataOut    (cpuDataOut),
      .z80Write      (z80Write),
      .outLED_cs     (outLED_cs),
      .iobyteOut_cs  (iobyteOut_cs),
      .usbTxD_cs     (usbTxD_cs),
      .outPortcon_cs (outPortcon_cs),
      .usbTxReady    (usbTxReady),
      .ledOut        (ledOut),
      .iobyteOut     (iobyteOut),
      .usbTxData     (usbTxData),
      .usbTxValid    (usbTxValid),
      .s100DataOut   (s100DataOut),
      .s100Wr        (s100Wr),
      .z80Wait       (z80Wait)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One Z80 write cycle; the reference model is updated by destination priority.
   task automatic cpuWrite(input logic [7:0] d, input logic led, input logic io,
                           input logic usb, input logic port, input logic trig,
                           input int hold, input logic chkWait);
      if (chkWait) begin
         int n = 0;
         while (z80Wait && n < 400) begin cycles(1); n++; end
         chk("wait_release", 32'(z80Wait), 0);
      end
      if (led)             ledExp = d;
      else if (io)         ioExp = d;
      else if (usb)        usbQ.push_back(d);
      else if (port && trig) s100Q.push_back(d);
      @(posedge clk); #1;
      cpuDataOut = d; outLED_cs = led; iobyteOut_cs = io; usbTxD_cs = usb; outPortcon_cs = port;
      z80Write = 1'b1;
      cycles(hold);
      z80Write = 1'b0;
      outLED_cs = 0; iobyteOut_cs = 0; usbTxD_cs = 0; outPortcon_cs = 0;
      cycles(SYNC + 2);
   endtask

   task automatic drain(input string name);
      int n = 0;
      readyMode = 1;
      while (usbQ.size() != 0 && n < 500) begin cycles(1); n++; end
      cycles(4);
      chk({name, "_empty"}, 32'(usbQ.size()), 0);
      chk({name, "_wait"}, 32'(z80Wait), 0);
   endtask

   // Ready driver
   initial forever begin
      @(posedge clk); #1;
      case (readyMode)
         0: usbTxReady = 1'b0;
         1: usbTxReady = 1'b1;
         default: usbTxReady = 1'($urandom_range(0, 1));
      endcase
   end

   // USB monitor
   initial forever begin
      @(negedge clk);
      if (n_reset && usbTxValid && usbTxReady) begin
         chk("usb_expected", 32'(usbQ.size() != 0), 1);
         if (usbQ.size() != 0) chk("usb_data", 32'(usbTxData), 32'(usbQ.pop_front()));
      end
   end

   // S100 monitor
   initial begin : s100Mon
      int  width = 0;
      bit  inPulse = 0;
      forever begin
         @(negedge clk);
         if (!n_reset) begin
            width = 0; inPulse = 0;
         end else if (s100Wr) begin
            if (!inPulse) begin
               inPulse = 1; width = 0;
               chk("s100_expected", 32'(s100Q.size() != 0), 1);
               if (s100Q.size() != 0) chk("s100_data", 32'(s100DataOut), 32'(s100Q.pop_front()));
            end
            width++;
         end else if (inPulse) begin
            chk("s100_width", width, WR_CYCLES);
            inPulse = 0;
         end
      end
   end

   initial begin
      cycles(3);
      chk("rst_led", 32'(ledOut), 32'h00);
      chk("rst_iobyte", 32'(iobyteOut), 32'hFF);
      chk("rst_valid", 32'(usbTxValid), 0);
      chk("rst_txdata", 32'(usbTxData), 0);
      chk("rst_s100data", 32'(s100DataOut), 0);
      chk("rst_s100wr", 32'(s100Wr), 0);
      chk("rst_wait", 32'(z80Wait), 0);
      n_reset = 1'b1;
      cycles(3);

      // LED write and priority
      cpuWrite(8'hA5, 1, 0, 0, 0, 0, SYNC + 2, 1);
      chk("led_a5", 32'(ledOut), 32'(ledExp));
      chk("led_io_untouched", 32'(iobyteOut), 32'(ioExp));
      cpuWrite(8'h3C, 1, 1, 0, 0, 0, SYNC + 2, 1);
      chk("prio_led", 32'(ledOut), 32'(ledExp));
      chk("prio_io", 32'(iobyteOut), 32'(ioExp));
      cpuWrite(8'h96, 0, 1, 1, 1, 0, SYNC + 2, 1);
      chk("prio_io2", 32'(iobyteOut), 32'(ioExp));

      // USB overflow: DEPTH fits, one more parks and stalls
      readyMode = 0; cycles(2);
      for (int i = 1; i <= DEPTH; i++) cpuWrite(8'(i), 0, 0, 1, 0, 0, 6, 1);
      chk("usb_full_nowait", 32'(z80Wait), 0);
      cpuWrite(8'(DEPTH + 1), 0, 0, 1, 0, 0, 6, 1);
      cycles(3);
      chk("usb_overflow_wait", 32'(z80Wait), 1);
      chk("usb_head_valid", 32'(usbTxValid), 1);
      chk("usb_head_data", 32'(usbTxData), 32'(usbQ[0]));
      drain("usb_overflow");

      // S100: long hold, ignored write mid-strobe, retrigger after release
      cpuWrite(8'h7E, 0, 0, 0, 1, 1, 40, 1);
      cycles(5);
      chk("s100_hold_data", 32'(s100DataOut), 32'h7E);
      cpuWrite(8'h11, 0, 0, 0, 1, 1, 4, 1);
      cpuWrite(8'h22, 0, 0, 0, 1, 0, 4, 1);
      cycles(30);
      chk("s100_ignored", 32'(s100DataOut), 32'h11);
      cpuWrite(8'h33, 0, 0, 0, 1, 1, 4, 1);
      cycles(30);
      chk("s100_retrig", 32'(s100DataOut), 32'h33);
      chk("s100_all_seen", 32'(s100Q.size()), 0);

      // Randomized LED / IOBYTE / USB traffic with random UART backpressure
      readyMode = 2;
      for (int i = 0; i < 60; i++) begin
         logic l, o, u;
         l = ($urandom_range(0, 3) == 0);
         o = ($urandom_range(0, 3) == 0);
         u = 1'($urandom_range(0, 1));
         cpuWrite(8'($urandom), l, o, u, 0, 0, $urandom_range(3, 8), 1);
         chk("rand_led", 32'(ledOut), 32'(ledExp));
         chk("rand_io", 32'(iobyteOut), 32'(ioExp));
      end
      drain("rand");

      // Reset mid-strobe with USB bytes outstanding
      cpuWrite(8'h5A, 1, 0, 0, 0, 0, 4, 1);
      cpuWrite(8'hC3, 0, 1, 0, 0, 0, 4, 1);
      readyMode = 0; cycles(2);
      cpuWrite(8'h10, 0, 0, 1, 0, 0, 6, 1);
      cpuWrite(8'h20, 0, 0, 1, 0, 0, 6, 1);
      cpuWrite(8'h55, 0, 0, 0, 1, 1, 6, 0);
      chk("pre_rst_strobe", 32'(s100Wr), 1);
      n_reset = 1'b0;
      #1;
      chk("mid_rst_s100wr", 32'(s100Wr), 0);
      chk("mid_rst_valid", 32'(usbTxValid), 0);
      chk("mid_rst_led", 32'(ledOut), 32'h00);
      chk("mid_rst_iobyte", 32'(iobyteOut), 32'hFF);
      chk("mid_rst_wait", 32'(z80Wait), 0);
      usbQ.delete();
      ledExp = 8'h00; ioExp = 8'hFF;
      cycles(3);
      n_reset = 1'b1;
      readyMode = 1;
      cycles(10);
      chk("post_rst_valid", 32'(usbTxValid), 0);
      chk("post_rst_s100data", 32'(s100DataOut), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
